// File: rtl/prog_lut_pkg.sv
// lut_pkg: shared types and default parameters for the prog_lut block.
//   lut_state_t    : sequencer state (LUT_INIT while self-initialising, LUT_READY after)
//   LUT_*          : default width/depth/ramp constants used by prog_lut
//   ramp_value()   : power-up content of entry idx (ramp for idx < count, else 0)
package lut_pkg;

    typedef enum logic {
        LUT_INIT  = 1'b0,
        LUT_READY = 1'b1
    } lut_state_t;

    localparam int LUT_DW         = 8;
    localparam int LUT_DEPTH      = 32;
    localparam int LUT_INIT_BASE  = 60;
    localparam int LUT_INIT_COUNT = 16;

    // Full 32-bit value; the caller truncates to the data width, which gives
    // the intended modulo-2^DW wrap of the ramp.
    function automatic logic [31:0] ramp_value(input int idx, input int base, input int count);
        logic [31:0] v;
        v = '0;
        if (idx < count) begin
            v = 32'(base + idx);
        end
        return v;
    endfunction

endpackage

// File: rtl/prog_lut_init_seq.sv
// lut_init_seq: power-up sequencer for prog_lut. Walks idx over every entry
// after reset, producing one init write per clock, then parks in LUT_READY.
//   clk, reset            : clock, synchronous active-high reset
//   busy                  : high while the table is being initialised
//   init_we/addr/data     : init write port into the storage array
//
//   state      | meaning
//   LUT_INIT   | writing entry idx each edge; user requests ignored
//   LUT_READY  | table initialised; user reads/writes served until reset
module lut_init_seq
    import lut_pkg::*;
#(
    parameter int DW         = LUT_DW,
    parameter int DEPTH      = LUT_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int INIT_BASE  = LUT_INIT_BASE,
    parameter int INIT_COUNT = LUT_INIT_COUNT
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data
);

    lut_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   ramp;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == LUT_INIT) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == AW'(DEPTH - 1)) begin
                state_d = LUT_READY;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LUT_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign ramp      = ramp_value(int'(idx_q), INIT_BASE, INIT_COUNT);
    assign busy      = (state_q == LUT_INIT);
    // No init write on a reset edge: the sequence restarts from idx 0 anyway.
    assign init_we   = busy && !reset;
    assign init_addr = idx_q;
    assign init_data = ramp[DW-1:0];

endmodule

// File: rtl/prog_lut.sv
// prog_lut: writable lookup table with self-initialisation and registered reads.
//   clk, reset                 : clock, synchronous active-high reset
//   rd_en, rd_addr             : read request; result one cycle later
//   rd_data, rd_valid          : registered read data and its one-cycle strobe
//   wr_en, wr_addr, wr_data    : write request (visible to a same-cycle read)
//   busy                       : initialisation in progress, requests ignored
//   err                        : one-cycle pulse, a request addressed >= DEPTH
module prog_lut
    import lut_pkg::*;
#(
    parameter int DW         = LUT_DW,
    parameter int DEPTH      = LUT_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int INIT_BASE  = LUT_INIT_BASE,
    parameter int INIT_COUNT = LUT_INIT_COUNT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          err
);

    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data;

    logic [DW-1:0] mem_q [DEPTH];

    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic ready;
    logic rd_in_range;
    logic wr_in_range;
    logic user_we;

    lut_init_seq #(
        .DW         (DW),
        .DEPTH      (DEPTH),
        .AW         (AW),
        .INIT_BASE  (INIT_BASE),
        .INIT_COUNT (INIT_COUNT)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    assign ready       = !busy;
    assign rd_in_range = (int'(rd_addr) < DEPTH);
    assign wr_in_range = (int'(wr_addr) < DEPTH);
    assign user_we     = ready && !reset && wr_en && wr_in_range;

    // Init and user writes never overlap: user writes are gated by ready.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end else if (user_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        if (ready) begin
            err_d = (rd_en && !rd_in_range) || (wr_en && !wr_in_range);
            if (rd_en) begin
                rd_valid_d = 1'b1;
                if (!rd_in_range) begin
                    rd_data_d = '0;
                end else if (wr_en && wr_in_range && (wr_addr == rd_addr)) begin
                    // write-first bypass
                    rd_data_d = wr_data;
                end else begin
                    rd_data_d = mem_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_lut.sv
module tb_prog_lut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: default parameters (DEPTH 32, base 60, count 16)
    logic       reset_a, rd_en_a, wr_en_a, rd_valid_a, busy_a, err_a;
    logic [4:0] rd_addr_a, wr_addr_a;
    logic [7:0] wr_data_a, rd_data_a;

    // DUT b: DEPTH 20, base 250, count 20
    logic       reset_b, rd_en_b, wr_en_b, rd_valid_b, busy_b, err_b;
    logic [4:0] rd_addr_b, wr_addr_b;
    logic [7:0] wr_data_b, rd_data_b;

    prog_lut u_dut_a (
        .clk(clk), .reset(reset_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .err(err_a)
    );

    prog_lut #(.DW(8), .DEPTH(20), .INIT_BASE(250), .INIT_COUNT(20)) u_dut_b (
        .clk(clk), .reset(reset_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd_en;
        logic [4:0] rd_addr;
        logic       wr_en;
        logic [4:0] wr_addr;
        logic [7:0] wr_data;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic idle_a();
        rd_en_a = 0; wr_en_a = 0; rd_addr_a = 0; wr_addr_a = 0; wr_data_a = 0;
    endtask

    task automatic idle_b();
        rd_en_b = 0; wr_en_b = 0; rd_addr_b = 0; wr_addr_b = 0; wr_data_b = 0;
    endtask

    // Reset a for one cycle, check reset outputs, then count busy cycles.
    task automatic reset_and_init_a(input string tag);
        int n;
        @(negedge clk);
        reset_a = 1;
        @(negedge clk);
        reset_a = 0;
        chk({tag, "_rst_busy"},  busy_a, 1);
        chk({tag, "_rst_valid"}, rd_valid_a, 0);
        chk({tag, "_rst_err"},   err_a, 0);
        chk({tag, "_rst_data"},  rd_data_a, 0);
        n = 0;
        while (busy_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_cycles"}, n, 32);
    endtask

    task automatic read_a(input string name, input logic [4:0] addr, input logic [7:0] exp);
        rd_en_a = 1; rd_addr_a = addr;
        @(negedge clk);
        rd_en_a = 0;
        chk({name, "_valid"}, rd_valid_a, 1);
        chk({name, "_data"},  rd_data_a, exp);
        chk({name, "_err"},   err_a, 0);
    endtask

    task automatic read_b(input string name, input logic [4:0] addr,
                          input logic [7:0] exp, input logic exp_err);
        rd_en_b = 1; rd_addr_b = addr;
        @(negedge clk);
        rd_en_b = 0;
        chk({name, "_valid"}, rd_valid_b, 1);
        chk({name, "_data"},  rd_data_b, exp);
        chk({name, "_err"},   err_b, exp_err);
    endtask

    initial begin
        int n;
        reset_a = 1; reset_b = 1;
        idle_a(); idle_b();

        vecs[0]  = '{1, 5'd0,  0, 5'd0, 8'h00, 1, 8'd60,  0};
        vecs[1]  = '{1, 5'd5,  0, 5'd0, 8'h00, 1, 8'd65,  0};
        vecs[2]  = '{1, 5'd15, 0, 5'd0, 8'h00, 1, 8'd75,  0};
        vecs[3]  = '{1, 5'd16, 0, 5'd0, 8'h00, 1, 8'd0,   0};
        vecs[4]  = '{1, 5'd31, 0, 5'd0, 8'h00, 1, 8'd0,   0};
        vecs[5]  = '{0, 5'd0,  1, 5'd3, 8'hA5, 0, 8'd0,   0};
        vecs[6]  = '{1, 5'd3,  0, 5'd0, 8'h00, 1, 8'hA5,  0};
        vecs[7]  = '{1, 5'd4,  0, 5'd0, 8'h00, 1, 8'd64,  0};
        vecs[8]  = '{1, 5'd7,  1, 5'd7, 8'h11, 1, 8'h11,  0};
        vecs[9]  = '{1, 5'd8,  1, 5'd9, 8'h33, 1, 8'd68,  0};
        vecs[10] = '{1, 5'd9,  0, 5'd0, 8'h00, 1, 8'h33,  0};
        vecs[11] = '{0, 5'd0,  0, 5'd0, 8'h00, 0, 8'h33,  0};

        // Initial init with requests held active while busy (must be ignored).
        @(negedge clk);
        @(negedge clk);
        chk("a_rst_busy", busy_a, 1);
        chk("a_rst_valid", rd_valid_a, 0);
        chk("a_rst_data", rd_data_a, 0);
        reset_a = 0;
        wr_en_a = 1; wr_addr_a = 0; wr_data_a = 8'hFF;
        rd_en_a = 1; rd_addr_a = 0;
        n = 0;
        while (busy_a && n < 100) begin
            @(negedge clk);
            n++;
            if (rd_valid_a !== 1'b0 || err_a !== 1'b0)
                chk("busy_ignored", {rd_valid_a, err_a}, 0);
        end
        chk("init_busy_cycles", n, 32);
        chk("busy_no_valid", rd_valid_a, 0);
        chk("busy_no_err", err_a, 0);
        idle_a();
        // first cycle with busy low: request accepted
        read_a("addr0_after_busy_write", 5'd0, 8'd60);

        // Table-driven back-to-back traffic.
        for (int i = 0; i < 12; i++) begin
            rd_en_a = vecs[i].rd_en; rd_addr_a = vecs[i].rd_addr;
            wr_en_a = vecs[i].wr_en; wr_addr_a = vecs[i].wr_addr; wr_data_a = vecs[i].wr_data;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), rd_valid_a, vecs[i].exp_valid);
            chk($sformatf("vec%0d_data", i),  rd_data_a,  vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i),   err_a,      vecs[i].exp_err);
        end
        idle_a();

        // Overwrite addr 2, then reset in READY (with a read in flight).
        wr_en_a = 1; wr_addr_a = 2; wr_data_a = 8'h00;
        @(negedge clk);
        idle_a();
        read_a("addr2_zeroed", 5'd2, 8'd0);
        rd_en_a = 1; rd_addr_a = 5'd2;
        reset_a = 1;
        @(negedge clk);
        reset_a = 0;
        idle_a();
        chk("ready_rst_valid", rd_valid_a, 0);
        chk("ready_rst_data",  rd_data_a, 0);
        chk("ready_rst_busy",  busy_a, 1);
        repeat (10) @(negedge clk);
        chk("mid_init_busy", busy_a, 1);
        // Reset again during INIT: full sequence restarts.
        reset_and_init_a("init_rst");
        read_a("addr2_restored", 5'd2, 8'd62);
        read_a("addr3_restored", 5'd3, 8'd63);

        // DEPTH 20 instance: wrap and out-of-range behaviour.
        @(negedge clk);
        reset_b = 0;
        n = 0;
        while (busy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_busy_cycles", n, 20);
        read_b("b_addr5", 5'd5, 8'd255, 0);
        read_b("b_addr6", 5'd6, 8'd0, 0);
        read_b("b_addr19", 5'd19, 8'd13, 0);
        read_b("b_addr25", 5'd25, 8'd0, 1);
        @(negedge clk);
        chk("b_err_one_cycle", err_b, 0);
        chk("b_valid_one_cycle", rd_valid_b, 0);
        wr_en_b = 1; wr_addr_b = 5'd25; wr_data_b = 8'h77;
        @(negedge clk);
        idle_b();
        chk("b_wr_oob_err", err_b, 1);
        chk("b_wr_oob_valid", rd_valid_b, 0);
        read_b("b_addr5_after_oob", 5'd5, 8'd255, 0);
        read_b("b_addr0_after_oob", 5'd0, 8'd250, 0);
        read_b("b_addr19_after_oob", 5'd19, 8'd13, 0);
        // OOB write alongside an in-range read: read completes, err still pulses.
        wr_en_b = 1; wr_addr_b = 5'd30; wr_data_b = 8'h55;
        rd_en_b = 1; rd_addr_b = 5'd6;
        @(negedge clk);
        idle_b();
        chk("b_mixed_valid", rd_valid_b, 1);
        chk("b_mixed_data", rd_data_b, 0);
        chk("b_mixed_err", err_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
